sys_mem_seq_ctrl: RTL and testbench

Top-level sequencer for the systolic scan datapath and its two 14-bit x 8-bit memories. It runs three phases in order:
- Load: streams N_WORDS host words into the input memory write port.
- Run: pulses scan start and waits for scan finish, with a timeout.
- Drain: reads the output memory in address order and streams the words back to the host with backpressure.

It replaces the free-running fill counter and sits between the host stream interfaces, MEM write/read ports and scan_new.

---
 rtl/sys_mem_pkg.sv | 20 ++
 rtl/sys_drain_fifo2.sv | 53 +++++
 rtl/sys_mem_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_sys_mem_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_mem_pkg.sv
// Shared defaults and state encoding for the memory sequencer.
// Imported by the sequencer top and its drain buffer.
package sys_mem_pkg;

  localparam int AW_DEF      = 14;
  localparam int DW_DEF      = 8;
  localparam int NWORDS_DEF  = 2500;
  localparam int TIMEOUT_DEF = 65535;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/sys_drain_fifo2.sv
// Two-entry drain buffer fed by a one-cycle-latency memory read.
// Reads are granted only when the data can never overflow the buffer.
module sys_drain_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic [DW-1:0] rd_data_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          can_issue_o
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          pend_q;
  logic          pop;
  logic [2:0]    occ;

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign pop         = out_valid_o & out_ready_i;

  // Occupancy after this cycle's pop, counting the read in flight.
  assign occ = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
  assign can_issue_o = (cnt_q != 2'd2) && (occ < 3'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      pend_q   <= 1'b0;
    end else begin
      pend_q <= issue_i;
      if (pend_q) begin
        mem_q[wr_ptr_q] <= rd_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/sys_mem_seq_ctrl.sv
// Load / scan / drain sequencer between the host streams,
// the two scan memories and the scan engine.
module sys_mem_seq_ctrl
  import sys_mem_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int N_WORDS = NWORDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic [DW-1:0] ld_data,
  output logic          scan_start,
  input  logic          scan_finish,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [2:0]    state
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST  = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] NW    = CW'(N_WORDS);
  localparam logic [15:0]   TLAST = 16'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]   timer_q, timer_d;
  logic          fin_q, fin_d;
  logic          ld_we_q, ld_we_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [DW-1:0] ld_data_q, ld_data_d;
  logic          start_q, start_d;
  logic          hs;
  logic          pop;
  logic          can_issue;
  logic          rd_go;

  assign in_ready = (state_q == S_LOAD);
  assign hs       = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    timer_d   = timer_q;
    fin_d     = fin_q;
    ld_we_d   = 1'b0;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    start_d   = 1'b0;
    rd_go     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          ld_we_d   = 1'b1;
          ld_addr_d = ld_cnt_q[AW-1:0];
          ld_data_d = in_data;
          ld_cnt_d  = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        timer_d = '0;
        fin_d   = scan_finish;
        state_d = S_RUN;
      end
      S_RUN: begin
        fin_d   = scan_finish;
        timer_d = timer_q + 16'd1;
        // Only a fresh rising edge counts; a stale level is ignored.
        if (scan_finish && !fin_q) begin
          state_d   = S_DRAIN;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end else if (timer_q == TLAST) begin
          state_d = S_ERR;
        end
      end
      S_DRAIN: begin
        rd_go = (rd_cnt_q < NW) && can_issue;
        if (rd_go) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (out_cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      timer_q   <= '0;
      fin_q     <= 1'b0;
      ld_we_q   <= 1'b0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      timer_q   <= timer_d;
      fin_q     <= fin_d;
      ld_we_q   <= ld_we_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      start_q   <= start_d;
    end
  end

  sys_drain_fifo2 #(
    .DW(DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (rd_go),
    .rd_data_i   (rd_data),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .can_issue_o (can_issue)
  );

  assign ld_we      = ld_we_q;
  assign ld_addr    = ld_addr_q;
  assign ld_data    = ld_data_q;
  assign scan_start = start_q;
  assign rd_en      = rd_go;
  assign rd_addr    = rd_go ? rd_cnt_q[AW-1:0] : '0;
  assign busy       = (state_q == S_LOAD) || (state_q == S_START) ||
                      (state_q == S_RUN)  || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign state      = state_q;

endmodule

// File: tb/tb_sys_mem_seq_ctrl.sv
// Directed + randomized bench for sys_mem_seq_ctrl against a
// queue/array model of the load, scan and drain phases.
module tb_sys_mem_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        go, in_valid, in_ready, ld_we, scan_start, scan_finish;
  logic [7:0]  in_data, ld_data, rd_data, out_data;
  logic [13:0] ld_addr, rd_addr;
  logic        rd_en, out_valid, out_ready, busy, done, err;
  logic [2:0]  state;

  logic        b_go, b_in_valid, b_in_ready, b_ld_we, b_scan_start;
  logic        b_scan_finish, b_rd_en, b_out_valid, b_out_ready;
  logic        b_busy, b_done, b_err;
  logic [7:0]  b_in_data, b_ld_data, b_rd_data, b_out_data;
  logic [13:0] b_ld_addr, b_rd_addr;
  logic [2:0]  b_state;

  logic [7:0]  omem  [8];
  logic [7:0]  bomem [2500];
  int          ncmp = 0;
  int          nerr = 0;
  int          cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    rd_data <= rd_en ? omem[rd_addr[2:0]] : 8'($urandom);
  always @(posedge clk)
    b_rd_data <= b_rd_en ? bomem[b_rd_addr] : 8'($urandom);

  sys_mem_seq_ctrl #(.N_WORDS(8), .TIMEOUT(50)) u_dut (
    .clk(clk), .rst(rst), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .scan_start(scan_start), .scan_finish(scan_finish),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  sys_mem_seq_ctrl u_big (
    .clk(clk), .rst(rst), .go(b_go),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .scan_start(b_scan_start), .scan_finish(b_scan_finish),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready),
    .busy(b_busy), .done(b_done), .err(b_err), .state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero();
    chk("z_in_ready",   32'(in_ready),   0);
    chk("z_ld_we",      32'(ld_we),      0);
    chk("z_ld_addr",    32'(ld_addr),    0);
    chk("z_ld_data",    32'(ld_data),    0);
    chk("z_scan_start", 32'(scan_start), 0);
    chk("z_rd_en",      32'(rd_en),      0);
    chk("z_rd_addr",    32'(rd_addr),    0);
    chk("z_out_valid",  32'(out_valid),  0);
    chk("z_out_data",   32'(out_data),   0);
    chk("z_busy",       32'(busy),       0);
    chk("z_done",       32'(done),       0);
    chk("z_err",        32'(err),        0);
    chk("z_state",      32'(state),      0);
  endtask

  // Ends at the sample point of the scan_start cycle.
  task automatic do_load(input bit toggle, input bit rnd);
    logic [7:0] q[$];
    int nwr, acc, first_we, last_we, nstart, start_c, k;
    bit busy_ok;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("load_state", 32'(state), 1);
    chk("load_err",   32'(err),   0);
    chk("load_done",  32'(done),  0);
    nwr = 0; acc = 0; first_we = -1; last_we = -1;
    nstart = 0; start_c = 0; busy_ok = 1'b1; k = 0;
    while (k < 60) begin
      in_valid = toggle ? ~k[0] : 1'b1;
      in_data  = rnd ? 8'($urandom) : 8'(8'h10 + acc);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (ld_we === 1'b1) begin
        chk("ld_extra", 32'(q.size() != 0), 1);
        if (q.size() != 0) chk("ld_data", 32'(ld_data), 32'(q.pop_front()));
        chk("ld_addr", 32'(ld_addr), 32'(nwr));
        nwr++;
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (scan_start === 1'b1) begin
        nstart++;
        start_c = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        acc++;
      end
      if (nstart != 0) break;
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk("start_seen", 32'(nstart), 1);
    chk("we_count", 32'(nwr), 8);
    chk("load_acc", 32'(acc), 8);
    chk("start_after_we", 32'(start_c - last_we), 1);
    if (!toggle) chk("we_consec", 32'(last_we - first_we), 7);
    chk("busy_load", 32'(busy_ok), 1);
    chk("run_state", 32'(state), 3);
  endtask

  // Ends at the sample point of the first DRAIN cycle.
  task automatic do_scan(input bit pre, input int fall_at,
                         input int rise_at);
    int enter;
    enter = -1;
    for (int i = 0; i < rise_at + 6; i++) begin
      if (i > 0) tick();
      scan_finish = (i >= rise_at) ? 1'b1 : ((i < fall_at) ? pre : 1'b0);
      #1;
      if (i == 1) chk("start_pulse", 32'(scan_start), 0);
      if (state === 3'd4) begin
        enter = i;
        break;
      end
    end
    chk("drain_entry", 32'(enter), 32'(rise_at + 1));
  endtask

  task automatic do_drain(input int mode, input int stop_at);
    int pat [6] = '{1, 0, 0, 1, 1, 0};
    int nrd, npop, held, drain0;
    logic prev_rd, prev_stall;
    logic [7:0] prev_d;
    drain0 = cyc; nrd = 0; npop = 0;
    prev_rd = 1'b0; prev_stall = 1'b0; prev_d = '0;
    for (int k = 0; k < 200 && npop < stop_at; k++) begin
      if (k > 0) tick();
      out_ready = (mode == 0) ? 1'b1 :
                  (mode == 1) ? 1'(pat[k % 6]) : 1'($urandom);
      #1;
      held = nrd - int'(prev_rd) - npop;
      if (rd_en === 1'b1) begin
        chk("rd_addr", 32'(rd_addr), 32'(nrd));
        chk("rd_held", 32'(held < 2), 1);
        chk("rd_range", 32'(nrd < 8), 1);
        nrd++;
      end
      if (prev_stall)
        chk("stall_stable", 32'({out_valid, out_data}), 32'({1'b1, prev_d}));
      if (out_valid && out_ready) begin
        chk("out_data", 32'(out_data), 32'(omem[npop]));
        if (mode == 0) chk("out_cycle", 32'(cyc - drain0), 32'(npop + 2));
        npop++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_rd = rd_en;
    end
    chk("drain_count", 32'(npop), 32'(stop_at));
    if (stop_at == 8) begin
      tick();
      chk("done_flag",  32'(done),  1);
      chk("done_state", 32'(state), 5);
      chk("done_busy",  32'(busy),  0);
      chk("done_rd_en", 32'(rd_en), 0);
    end
  endtask

  initial begin
    int e, nw, bad, npop;
    logic [7:0] bq[$];
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0;
    scan_finish = 1'b0; out_ready = 1'b0;
    b_go = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    b_scan_finish = 1'b0; b_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) omem[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 2500; i++) bomem[i] = 8'($urandom);
    #3;
    chk_zero();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // constant in_valid, finish rises 5 cycles into RUN
    do_load(1'b0, 1'b0);
    do_scan(1'b0, 0, 5);
    do_drain(0, 8);

    // toggling in_valid, stale finish, backpressure pattern
    for (int i = 0; i < 8; i++) omem[i] = 8'($urandom);
    do_load(1'b1, 1'b1);
    do_scan(1'b1, 3, 23);
    do_drain(1, 8);

    // timeout with finish held low
    scan_finish = 1'b0;
    do_load(1'b0, 1'b0);
    e = -1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) tick();
      #1;
      if (state === 3'd6) begin
        e = i;
        break;
      end
    end
    chk("tmo_cycle", 32'(e), 50);
    chk("tmo_err",   32'(err), 1);
    chk("tmo_busy",  32'(busy), 0);

    // restart from ERR, then asynchronous reset mid-drain
    for (int i = 0; i < 8; i++) omem[i] = 8'(8'hA0 + i);
    do_load(1'b0, 1'b0);
    do_scan(1'b0, 0, 4);
    do_drain(0, 3);
    rst = 1'b1;
    #1;
    chk_zero();
    tick();
    rst = 1'b0;
    scan_finish = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 0);
    for (int i = 0; i < 8; i++) omem[i] = 8'($urandom);
    do_load(1'b0, 1'b1);
    do_scan(1'b0, 0, 3);
    do_drain(2, 8);

    // full-size run on the default configuration
    b_go = 1'b1;
    tick();
    b_go = 1'b0;
    chk("big_load_state", 32'(b_state), 1);
    nw = 0; bad = 0;
    for (int k = 0; k < 10000; k++) begin
      b_in_valid = ($urandom % 4) != 0;
      b_in_data  = 8'($urandom);
      #1;
      if (b_ld_we === 1'b1) begin
        if (bq.size() == 0) bad++;
        else if (b_ld_data !== bq.pop_front()) bad++;
        if (b_ld_addr !== 14'(nw)) bad++;
        nw++;
      end
      if (b_in_valid && b_in_ready) bq.push_back(b_in_data);
      if (b_scan_start === 1'b1) break;
      tick();
    end
    b_in_valid = 1'b0;
    chk("big_we", 32'(nw), 2500);
    chk("big_wbad", 32'(bad), 0);
    repeat (3) tick();
    b_scan_finish = 1'b1;
    for (int k = 0; k < 20 && b_state !== 3'd4; k++) tick();
    chk("big_drain", 32'(b_state), 4);
    npop = 0; bad = 0;
    for (int k = 0; k < 20000 && b_done !== 1'b1; k++) begin
      b_out_ready = 1'($urandom);
      #1;
      if (b_out_valid && b_out_ready) begin
        if (npop >= 2500 || b_out_data !== bomem[npop]) bad++;
        npop++;
      end
      tick();
    end
    chk("big_pops", 32'(npop), 2500);
    chk("big_rbad", 32'(bad), 0);
    chk("big_done", 32'(b_done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
